uart_wb_bridge: RTL

UART_WB_BRIDGE -- requirements
Module: uart_wb_bridge

---
 rtl/uart_wb_bridge.sv | 387 ++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_wb_bridge.sv
// ---------------------------------------------------------------------------
// uart_wb_bridge
//   Bridges a byte-wide internal command port (as used behind a UART command
//   decoder) onto a Wishbone pipelined master. Byte writes are gathered into
//   a word-wide lane buffer and flushed as a single sel-masked bus write. Byte
//   reads fetch a whole word, which is then kept in a one-word read cache.
//
//   Optional feature: define UART_WB_TIMEOUT_EN to enable the ack watchdog.
//   When enabled, a bus transaction that has not completed within TIMEOUT
//   cycles is abandoned and err_o is set. err_o stays set until reset. When
//   the macro is undefined, err_o is tied low and the bridge waits
//   indefinitely for ack_i.
//
// Parameters
//   DATA_W    Wishbone data width (16 or 32)
//   ADDR_W    Wishbone address width
//   BASE_ADDR offset added to every bus byte address
//   TIMEOUT   ack watchdog limit in cycles (UART_WB_TIMEOUT_EN only)
//
// Ports
//   clk_i, rst_n_i     single clock, asynchronous active-low reset
//   int_address[15:0]  byte address from the command port
//   int_wr_data[7:0]   write byte
//   int_write          write strobe (has priority over int_read)
//   int_read           read strobe
//   int_req            command port requests the bridge
//   int_gnt            bridge idle and request present; strobes taken only now
//   int_rd_data[7:0]   read byte, updated when a read completes
//   cyc_o, stb_o, we_o Wishbone cycle, strobe and write enable
//   sel_o              Wishbone byte selects
//   addr_o             Wishbone byte address of lane 0 of the word
//   data_o / data_i    Wishbone write / read data
//   stall_i, ack_i     Wishbone stall and acknowledge
//   err_o              sticky timeout flag
// ---------------------------------------------------------------------------
module uart_wb_bridge #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [15:0]         int_address,
  input  logic [7:0]          int_wr_data,
  input  logic                int_write,
  input  logic                int_read,
  input  logic                int_req,
  output logic                int_gnt,
  output logic [7:0]          int_rd_data,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                we_o,
  output logic [DATA_W/8-1:0] sel_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   data_o,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                stall_i,
  input  logic                ack_i,
  output logic                err_o
);

  localparam int NL = DATA_W / 8;     // byte lanes per word
  localparam int LW = $clog2(NL);     // lane index width
  localparam int TW = 16 - LW;        // word tag width

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_ACK = 3'd2,
    RD_REQ = 3'd3,
    RD_ACK = 3'd4
  } state_t;

  // Byte-enable mask expanded from a lane select vector.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [NL-1:0] sel);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < NL; i++) begin
      m[i*8 +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

  // Word with one byte lane replaced.
  function automatic logic [DATA_W-1:0] put_lane(input logic [DATA_W-1:0] w,
                                                 input logic [LW-1:0]     l,
                                                 input logic [7:0]        b);
    logic [DATA_W-1:0] r;
    r = w;
    r[{l, 3'b000} +: 8] = b;
    return r;
  endfunction

  // One byte lane of a word.
  function automatic logic [7:0] get_lane(input logic [DATA_W-1:0] w,
                                          input logic [LW-1:0]     l);
    return w[{l, 3'b000} +: 8];
  endfunction

  // One-hot lane select.
  function automatic logic [NL-1:0] lane_bit(input logic [LW-1:0] l);
    logic [NL-1:0] one;
    one = {{(NL-1){1'b0}}, 1'b1};
    return one << l;
  endfunction

  // Bus byte address of lane 0 of a word tag.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [TW-1:0] t);
    return BASE_ADDR + ADDR_W'({t, {LW{1'b0}}});
  endfunction

  state_t            state_r, state_nxt_s;

  // write gather buffer
  logic [DATA_W-1:0] wbuf_r;
  logic [NL-1:0]     pend_r;
  logic [TW-1:0]     wtag_r;
  // one-word read cache
  logic [DATA_W-1:0] cache_r;
  logic [TW-1:0]     cache_tag_r;
  logic              cache_vld_r;
  // command held back while an older word is flushed
  logic              dfr_vld_r;
  logic              dfr_wr_r;
  logic [15:0]       dfr_addr_r;
  logic [7:0]        dfr_data_r;
  // outstanding bus read
  logic [LW-1:0]     rd_lane_r;
  logic [TW-1:0]     rd_tag_r;

  logic [LW-1:0]     lane_s, dfr_lane_s;
  logic [TW-1:0]     tag_s, dfr_tag_s;
  logic              gnt_s, wr_s, rd_s, last_s, dfr_last_s;
  logic              wr_conflict_s, rd_flush_s, rd_hit_s, rd_miss_s;
  logic              bus_done_s, tmo_s;
  logic [NL-1:0]     pend_merge_s, dfr_bit_s;
  logic [DATA_W-1:0] wbuf_merge_s, dfr_merge_s;

  assign lane_s     = int_address[LW-1:0];
  assign tag_s      = int_address[15:LW];
  assign dfr_lane_s = dfr_addr_r[LW-1:0];
  assign dfr_tag_s  = dfr_addr_r[15:LW];

  // Grant is withheld during reset even though the state already reads IDLE.
  assign gnt_s = rst_n_i && (state_r == IDLE) && int_req;
  assign wr_s  = gnt_s && int_write;
  assign rd_s  = gnt_s && int_read && !int_write;

  assign last_s       = (lane_s == LW'(NL-1));
  assign dfr_last_s   = (dfr_lane_s == LW'(NL-1));
  assign pend_merge_s = pend_r | lane_bit(lane_s);
  assign wbuf_merge_s = put_lane(wbuf_r, lane_s, int_wr_data);
  assign dfr_bit_s    = lane_bit(dfr_lane_s);
  assign dfr_merge_s  = put_lane(wbuf_r, dfr_lane_s, dfr_data_r);

  // A write to another word, or a read of the pending word, must flush first.
  assign wr_conflict_s = wr_s && (|pend_r) && (tag_s != wtag_r);
  assign rd_flush_s    = rd_s && (|pend_r) && (tag_s == wtag_r);
  assign rd_hit_s      = rd_s && !rd_flush_s && cache_vld_r && (cache_tag_r == tag_s);
  assign rd_miss_s     = rd_s && !rd_flush_s && !rd_hit_s;

  // ack_i is only meaningful while waiting for it.
  assign bus_done_s = ((state_r == WR_ACK) || (state_r == RD_ACK)) && ack_i;

`ifdef UART_WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt_r;
  logic          err_r;

  assign tmo_s = (state_r != IDLE) && !bus_done_s && (tmo_cnt_r == CW'(TIMEOUT - 1));

  // Watchdog: counts every cycle of one bus transaction, request through ack.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == IDLE) || bus_done_s || tmo_s) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + CW'(1);
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_r <= 1'b0;
    end else if (tmo_s) begin
      err_r <= 1'b1;
    end
  end
`else
  assign tmo_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (tmo_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (wr_s) begin
            if (wr_conflict_s || last_s) begin
              state_nxt_s = WR_REQ;
            end else begin
              state_nxt_s = IDLE;
            end
          end else if (rd_flush_s) begin
            state_nxt_s = WR_REQ;
          end else if (rd_miss_s) begin
            state_nxt_s = RD_REQ;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        WR_REQ: begin
          if (!stall_i) begin
            state_nxt_s = WR_ACK;
          end else begin
            state_nxt_s = WR_REQ;
          end
        end
        WR_ACK: begin
          // A held-back command may itself need the bus straight away.
          if (!ack_i) begin
            state_nxt_s = WR_ACK;
          end else if (dfr_vld_r && dfr_wr_r && dfr_last_s) begin
            state_nxt_s = WR_REQ;
          end else if (dfr_vld_r && !dfr_wr_r) begin
            state_nxt_s = RD_REQ;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RD_REQ: begin
          if (!stall_i) begin
            state_nxt_s = RD_ACK;
          end else begin
            state_nxt_s = RD_REQ;
          end
        end
        RD_ACK: begin
          if (ack_i) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = RD_ACK;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Bus control and grant decoded from the registered state.
  always_comb begin
    int_gnt = gnt_s;
`ifdef UART_WB_TIMEOUT_EN
    err_o   = err_r;
`else
    err_o   = 1'b0;
`endif
    case (state_r)
      WR_REQ:  begin cyc_o = 1'b1; stb_o = 1'b1; we_o = 1'b1; end
      WR_ACK:  begin cyc_o = 1'b1; stb_o = 1'b0; we_o = 1'b1; end
      RD_REQ:  begin cyc_o = 1'b1; stb_o = 1'b1; we_o = 1'b0; end
      RD_ACK:  begin cyc_o = 1'b1; stb_o = 1'b0; we_o = 1'b0; end
      default: begin cyc_o = 1'b0; stb_o = 1'b0; we_o = 1'b0; end
    endcase
  end

  // Datapath: gather buffer, read cache, held-back command and bus payload.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wbuf_r      <= '0;
      pend_r      <= '0;
      wtag_r      <= '0;
      cache_r     <= '0;
      cache_tag_r <= '0;
      cache_vld_r <= 1'b0;
      dfr_vld_r   <= 1'b0;
      dfr_wr_r    <= 1'b0;
      dfr_addr_r  <= 16'h0000;
      dfr_data_r  <= 8'h00;
      rd_lane_r   <= '0;
      rd_tag_r    <= '0;
      addr_o      <= '0;
      sel_o       <= '0;
      data_o      <= '0;
      int_rd_data <= 8'h00;
    end else if (tmo_s) begin
      // Abandoned transaction: drop everything queued; reads report 0xEE.
      pend_r    <= '0;
      dfr_vld_r <= 1'b0;
      if ((state_r == RD_REQ) || (state_r == RD_ACK) || (dfr_vld_r && !dfr_wr_r)) begin
        int_rd_data <= 8'hEE;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (wr_s) begin
            if (wr_conflict_s) begin
              dfr_vld_r  <= 1'b1;
              dfr_wr_r   <= 1'b1;
              dfr_addr_r <= int_address;
              dfr_data_r <= int_wr_data;
              addr_o     <= word_addr(wtag_r);
              sel_o      <= pend_r;
              data_o     <= wbuf_r & lane_mask(pend_r);
            end else begin
              wbuf_r <= wbuf_merge_s;
              pend_r <= pend_merge_s;
              wtag_r <= tag_s;
              if (last_s) begin
                addr_o <= word_addr(tag_s);
                sel_o  <= pend_merge_s;
                data_o <= wbuf_merge_s & lane_mask(pend_merge_s);
              end
            end
          end else if (rd_flush_s) begin
            dfr_vld_r  <= 1'b1;
            dfr_wr_r   <= 1'b0;
            dfr_addr_r <= int_address;
            addr_o     <= word_addr(wtag_r);
            sel_o      <= pend_r;
            data_o     <= wbuf_r & lane_mask(pend_r);
          end else if (rd_hit_s) begin
            int_rd_data <= get_lane(cache_r, lane_s);
          end else if (rd_miss_s) begin
            rd_lane_r <= lane_s;
            rd_tag_r  <= tag_s;
            addr_o    <= word_addr(tag_s);
            sel_o     <= '1;
            data_o    <= '0;
          end
        end
        WR_ACK: begin
          if (ack_i) begin
            pend_r    <= '0;
            dfr_vld_r <= 1'b0;
            // The cached copy of the flushed word is now stale.
            if (cache_tag_r == wtag_r) begin
              cache_vld_r <= 1'b0;
            end
            if (dfr_vld_r && dfr_wr_r) begin
              wbuf_r <= dfr_merge_s;
              pend_r <= dfr_bit_s;
              wtag_r <= dfr_tag_s;
              if (dfr_last_s) begin
                addr_o <= word_addr(dfr_tag_s);
                sel_o  <= dfr_bit_s;
                data_o <= dfr_merge_s & lane_mask(dfr_bit_s);
              end
            end else if (dfr_vld_r) begin
              rd_lane_r <= dfr_lane_s;
              rd_tag_r  <= dfr_tag_s;
              addr_o    <= word_addr(dfr_tag_s);
              sel_o     <= '1;
              data_o    <= '0;
            end
          end
        end
        RD_ACK: begin
          if (ack_i) begin
            cache_r     <= data_i;
            cache_tag_r <= rd_tag_r;
            cache_vld_r <= 1'b1;
            int_rd_data <= get_lane(data_i, rd_lane_r);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
